// File: rtl/imem_loader_ctrl.sv
// Boot loader / fetch arbiter for the instruction RAM: length-prefixed UART image -> RAM, then core fetch.
// Latency: last byte at t -> mem_we at t+1, stall release at t+2; rx_ready has no backpressure while loading.
module imem_loader_ctrl #(
   parameter int DEPTH_LOG2 = 10,
   parameter int PC_W       = 27
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  rx_ready,
   input  logic                  reload,
   input  logic [PC_W-1:0]       pc,
   input  logic                  fetch_req,
   output logic                  inst_valid,
   output logic                  core_stall,
   output logic                  load_done,
   output logic                  load_err,
   output logic                  mem_we,
   output logic [DEPTH_LOG2-1:0] mem_waddr,
   output logic [31:0]           mem_wdata,
   output logic [DEPTH_LOG2-1:0] mem_raddr
);

   typedef enum logic [1:0] {S_LEN, S_DATA, S_RUN, S_ERR} state_t;

   localparam logic [31:0] MAX_LEN = 32'd1 << DEPTH_LOG2;

   state_t                state_q, state_d;
   logic [1:0]            byte_cnt_q;
   logic [23:0]           asm_q;
   logic [DEPTH_LOG2:0]   word_cnt_q;
   logic [DEPTH_LOG2:0]   len_q;
   logic                  wr_pend_q;
   logic [DEPTH_LOG2-1:0] wr_addr_q;
   logic [31:0]           wr_data_q;
   logic                  fetch_q;

   logic        accept;
   logic        word_done;
   logic [31:0] word;
   logic        last_wr;
   logic        done;
   logic        unused_pc;

   assign accept    = rx_valid & rx_ready;
   assign word_done = accept && (byte_cnt_q == 2'd3);
   assign word      = {rx_data, asm_q};
   // word_cnt_q has already advanced past the pending write
   assign last_wr   = wr_pend_q && (word_cnt_q == len_q);
   assign unused_pc = ^{pc[PC_W-1:DEPTH_LOG2+2], pc[1:0]};

   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      case (state_q)
         S_LEN: begin
            if (word_done) begin
               if (word == 32'd0) begin
                  state_d = S_RUN;
                  done    = 1'b1;
               end else if (word > MAX_LEN) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (last_wr) begin
               state_d = S_RUN;
               done    = 1'b1;
            end
         end
         S_RUN: begin
            if (reload) state_d = S_LEN;
         end
         default: state_d = S_ERR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_LEN;
         byte_cnt_q <= 2'd0;
         asm_q      <= 24'd0;
         word_cnt_q <= '0;
         len_q      <= '0;
         wr_pend_q  <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= 32'd0;
         fetch_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         fetch_q   <= (state_q == S_RUN) && fetch_req && !reload;
         wr_pend_q <= (state_q == S_DATA) && word_done;
         if (accept) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            case (byte_cnt_q)
               2'd0:    asm_q[7:0]   <= rx_data;
               2'd1:    asm_q[15:8]  <= rx_data;
               2'd2:    asm_q[23:16] <= rx_data;
               default: ;
            endcase
         end
         if ((state_q == S_LEN) && word_done) begin
            len_q      <= word[DEPTH_LOG2:0];
            word_cnt_q <= '0;
         end
         if ((state_q == S_DATA) && word_done) begin
            wr_addr_q  <= word_cnt_q[DEPTH_LOG2-1:0];
            wr_data_q  <= word;
            word_cnt_q <= word_cnt_q + 1'b1;
         end
         if ((state_q == S_RUN) && reload) begin
            byte_cnt_q <= 2'd0;
            word_cnt_q <= '0;
         end
      end
   end

   // Everything is gated by rst so outputs are quiet during the reset cycles themselves
   assign rx_ready   = !rst && ((state_q == S_LEN) || (state_q == S_DATA));
   assign core_stall = rst || (state_q != S_RUN);
   assign load_done  = !rst && done;
   assign load_err   = !rst && (state_q == S_ERR);
   assign mem_we     = !rst && wr_pend_q && (state_q == S_DATA);
   assign mem_waddr  = mem_we ? wr_addr_q : '0;
   assign mem_wdata  = mem_we ? wr_data_q : 32'd0;
   assign mem_raddr  = (!rst && (state_q == S_RUN)) ? pc[DEPTH_LOG2+1:2] : '0;
   assign inst_valid = !rst && fetch_q;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Directed bench for imem_loader_ctrl; RAM writes are checked against a queue of expected {addr,data}.
module tb_imem_loader_ctrl;

   localparam int DL = 10;
   localparam int PW = 27;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          rx_ready;
   logic          reload;
   logic [PW-1:0] pc;
   logic          fetch_req;
   logic          inst_valid;
   logic          core_stall;
   logic          load_done;
   logic          load_err;
   logic          mem_we;
   logic [DL-1:0] mem_waddr;
   logic [31:0]   mem_wdata;
   logic [DL-1:0] mem_raddr;

   imem_loader_ctrl #(.DEPTH_LOG2(DL), .PC_W(PW)) dut (
      .clk(clk), .rst(rst),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .reload(reload), .pc(pc), .fetch_req(fetch_req),
      .inst_valid(inst_valid), .core_stall(core_stall),
      .load_done(load_done), .load_err(load_err),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .mem_raddr(mem_raddr)
   );

   always #5 clk = ~clk;

   int          n_pass  = 0;
   int          n_total = 0;
   int          n_wr    = 0;
   int          wr_before;
   logic [41:0] sb_q[$];
   logic [41:0] sb_e;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic send_word_gap(input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 3));
         send_byte(w[8*i +: 8]);
      end
   endtask

   task automatic expect_wr(input logic [DL-1:0] a, input logic [31:0] d);
      sb_q.push_back({a, d});
   endtask

   always @(negedge clk) begin
      if (mem_we) begin
         n_wr++;
         if (sb_q.size() == 0) begin
            check("we_unexpected", mem_we, 32'd0);
         end else begin
            sb_e = sb_q.pop_front();
            check("we_addr", mem_waddr, sb_e[41:32]);
            check("we_data", mem_wdata, sb_e[31:0]);
         end
      end
      if (load_done) check("done_err_excl", load_err, 32'd0);
   end

   initial begin
      rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; reload = 1'b0; fetch_req = 1'b1; pc = '0;
      tick(3);
      check("rst_rx_ready", rx_ready, 0);
      check("rst_stall", core_stall, 1);
      check("rst_we", mem_we, 0);
      check("rst_err", load_err, 0);
      check("rst_done", load_done, 0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_raddr", mem_raddr, 0);
      rst = 1'b0;
      tick(2);
      check("len_inst_valid", inst_valid, 0);
      check("len_stall", core_stall, 1);
      check("len_rx_ready", rx_ready, 1);
      fetch_req = 1'b0;

      // N=2 image, contiguous bytes
      expect_wr(0, 32'h0000_0013);
      expect_wr(1, 32'h0010_0093);
      send_word(32'd2);
      send_word(32'h0000_0013);
      send_word(32'h0010_0093);
      check("n2_we_t1", mem_we, 1);
      check("n2_waddr_t1", mem_waddr, 1);
      check("n2_done_t1", load_done, 1);
      check("n2_stall_t1", core_stall, 1);
      tick(1);
      check("n2_stall_t2", core_stall, 0);
      check("n2_done_t2", load_done, 0);
      check("n2_we_t2", mem_we, 0);
      check("run_rx_ready", rx_ready, 0);

      // fetch, including 4 KiB wrap
      pc = 27'h4; fetch_req = 1'b1;
      #1 check("fetch_raddr", mem_raddr, 1);
      tick(1);
      check("fetch_valid", inst_valid, 1);
      pc = 27'h1004;
      #1 check("fetch_wrap_raddr", mem_raddr, 1);
      tick(1);
      check("fetch_wrap_valid", inst_valid, 1);
      fetch_req = 1'b0;
      tick(1);
      check("fetch_idle_valid", inst_valid, 0);

      // reload with concurrent fetch_req, then N=0
      reload = 1'b1; fetch_req = 1'b1;
      tick(1);
      reload = 1'b0; fetch_req = 1'b0;
      check("reload_inst_valid", inst_valid, 0);
      check("reload_stall", core_stall, 1);
      check("reload_rx_ready", rx_ready, 1);
      wr_before = n_wr;
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      rx_valid = 1'b1; rx_data = 8'h00;
      #1 check("n0_done", load_done, 1);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      check("n0_stall", core_stall, 0);
      check("n0_done_clear", load_done, 0);
      tick(2);
      check("n0_no_we", n_wr, wr_before);

      // N=3 with random byte gaps
      reload = 1'b1; tick(1); reload = 1'b0;
      expect_wr(0, 32'h1111_2222);
      expect_wr(1, 32'h3333_4444);
      expect_wr(2, 32'hA5A5_5A5A);
      send_word_gap(32'd3);
      send_word_gap(32'h1111_2222);
      send_word_gap(32'h3333_4444);
      send_word_gap(32'hA5A5_5A5A);
      tick(2);
      check("gap_stall", core_stall, 0);
      check("gap_drain", sb_q.size(), 0);

      // reset after 6 bytes of an N=4 load
      reload = 1'b1; tick(1); reload = 1'b0;
      send_word(32'd4);
      send_byte(8'hAA); send_byte(8'hBB);
      rst = 1'b1;
      tick(1);
      check("midrst_rx_ready", rx_ready, 0);
      check("midrst_stall", core_stall, 1);
      rst = 1'b0;
      tick(1);
      check("postrst_rx_ready", rx_ready, 1);
      check("postrst_stall", core_stall, 1);
      expect_wr(0, 32'hDEAD_BEEF);
      send_word(32'd1);
      send_word(32'hDEAD_BEEF);
      tick(1);
      check("postrst_run", core_stall, 0);
      reload = 1'b1; fetch_req = 1'b1;
      tick(1);
      reload = 1'b0; fetch_req = 1'b0;
      check("reload2_inst_valid", inst_valid, 0);
      check("reload2_stall", core_stall, 1);

      // N=1024: full RAM
      for (int i = 0; i < 1024; i++) expect_wr(i[DL-1:0], 32'hC0DE_0000 | i);
      send_word(32'd1024);
      for (int i = 0; i < 1024; i++) send_word(32'hC0DE_0000 | i);
      check("n1024_last_waddr", mem_waddr, 1023);
      check("n1024_done", load_done, 1);
      tick(1);
      check("n1024_stall", core_stall, 0);

      // N=1025 -> ERR
      reload = 1'b1; tick(1); reload = 1'b0;
      send_word(32'd1025);
      check("err_flag", load_err, 1);
      check("err_rx_ready", rx_ready, 0);
      check("err_stall", core_stall, 1);
      check("err_done", load_done, 0);
      rx_valid = 1'b1; rx_data = 8'h05; reload = 1'b1;
      tick(2);
      rx_valid = 1'b0; reload = 1'b0;
      check("err_sticky", load_err, 1);
      check("err_sticky_stall", core_stall, 1);
      rst = 1'b1;
      tick(1);
      check("err_rst_clear", load_err, 0);
      rst = 1'b0;
      tick(1);
      check("sb_drain", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
